// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM encoding, header sizes,
// default parameter values and the payload-length helper.
package udp_tx_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT_TX, GAP} state_t;

    localparam int UDP_HDR_BYTES      = 8;
    localparam int IP_HDR_BYTES       = 20;
    localparam int IFG_CYCLES_DEF     = 24;
    localparam int TIMEOUT_CYCLES_DEF = 65535;
    localparam int MIN_WORDS_DEF      = 5;

    // Short payloads are padded up to min_words so the frame meets the minimum size.
    function automatic logic [15:0] payload_bytes(input logic [8:0] words, input int min_words);
        logic [15:0] w;
        w = {7'd0, words};
        if (w < 16'(min_words)) w = 16'(min_words);
        return {w[13:0], 2'b00};
    endfunction
endpackage

// File: rtl/udp_rr_arb2.sv
// Two-way combinational round-robin arbiter; 'last' is the index served most
// recently, so the other requester wins a tie.
module udp_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (last) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end
endmodule

// File: rtl/udp_tx_sched.sv
// Frame scheduler in front of the UDP/IP sender: arbitrates two requesters,
// starts one frame at a time and enforces the inter-frame gap.
// Optional WAIT_TX watchdog enabled by defining UDP_TX_SCHED_TIMEOUT_EN.
module udp_tx_sched
    import udp_tx_pkg::*;
#(
    parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int MIN_WORDS      = MIN_WORDS_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  req,
    input  logic [8:0]  req_words0,
    input  logic [8:0]  req_words1,
    input  logic        tx_finish,
    output logic        start,
    output logic [15:0] mydata_num,
    output logic [15:0] total_len,
    output logic [1:0]  gnt,
    output logic        sel,
    output logic [1:0]  done,
    output logic        busy
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    ,
    output logic        err_timeout
`endif
);
    state_t      state;
    logic        last;
    logic [15:0] gap_cnt;
    logic [1:0]  arb_gnt;
    logic [15:0] bytes;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    logic [15:0] to_cnt;
`endif

    udp_rr_arb2 u_arb (.req(req), .last(last), .gnt(arb_gnt));

    assign bytes = payload_bytes(arb_gnt[1] ? req_words1 : req_words0, MIN_WORDS);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            last       <= 1'b1;  // requester 0 wins the first arbitration
            gap_cnt    <= '0;
            start      <= 1'b0;
            gnt        <= '0;
            sel        <= 1'b0;
            done       <= '0;
            mydata_num <= '0;
            total_len  <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
            to_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            done  <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: if (|req) begin
                    gnt        <= arb_gnt;
                    sel        <= arb_gnt[1];
                    last       <= arb_gnt[1];
                    mydata_num <= bytes + 16'(UDP_HDR_BYTES);
                    total_len  <= bytes + 16'(UDP_HDR_BYTES + IP_HDR_BYTES);
                    state      <= START;
                end
                START: begin
                    start <= 1'b1;
                    state <= WAIT_TX;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_TX: begin
                    if (tx_finish) begin
                        done    <= gnt;
                        gnt     <= '0;
                        gap_cnt <= 16'(IFG_CYCLES);
                        state   <= GAP;
                    end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                    else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        done        <= gnt;
                        gnt         <= '0;
                        gap_cnt     <= 16'(IFG_CYCLES);
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == 16'd0) state <= IDLE;
                    else                  gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
